// File: rtl/des_byte_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : des_byte_sequencer_if
// Brief    : Byte-stream and DES-core signal bundle for des_byte_sequencer.
// Revision : 1.0
// ============================================================================
interface des_byte_sequencer_if;
  logic        CHIP_BAR_I;
  logic        IN_VALID;
  logic        IN_READY;
  logic [7:0]  PT_BYTE_I;
  logic [7:0]  KEY_BYTE_I;
  logic [63:0] DES_PT_O;
  logic [63:0] DES_KEY_O;
  logic        DES_START_O;
  logic [63:0] DES_CIPHER_I;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [7:0]  CIPHER_BYTE_O;
  logic        OUT_LAST;
  logic        BUSY;

  // Sequencer side
  modport slave (
    input  CHIP_BAR_I, IN_VALID, PT_BYTE_I, KEY_BYTE_I, DES_CIPHER_I, OUT_READY,
    output IN_READY, DES_PT_O, DES_KEY_O, DES_START_O, OUT_VALID, CIPHER_BYTE_O,
           OUT_LAST, BUSY
  );

  // Pin / core side
  modport master (
    output CHIP_BAR_I, IN_VALID, PT_BYTE_I, KEY_BYTE_I, DES_CIPHER_I, OUT_READY,
    input  IN_READY, DES_PT_O, DES_KEY_O, DES_START_O, OUT_VALID, CIPHER_BYTE_O,
           OUT_LAST, BUSY
  );
endinterface
`default_nettype wire

// File: rtl/des_byte_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : des_byte_sequencer
// Brief    : Loads 8 pt/key byte pairs, starts the DES core, waits its fixed
//            latency and streams the 64-bit cipher back out byte by byte.
// Revision : 1.0
// ============================================================================
module des_byte_sequencer #(
  parameter int unsigned DES_LATENCY = 16
) (
  input  wire logic            CLKI,
  input  wire logic            RSTI,
  des_byte_sequencer_if.slave  bus
);

  localparam logic [1:0] ST_LOAD   = 2'd0;
  localparam logic [1:0] ST_START  = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_UNLOAD = 2'd3;
  localparam logic [7:0] C_LATENCY = 8'(DES_LATENCY);

  logic [1:0]  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  wait_q, wait_d;
  logic [63:0] pt_q, pt_d;
  logic [63:0] key_q, key_d;
  logic [63:0] shift_q, shift_d;

  logic run;
  logic in_ready;
  logic out_valid;
  logic in_hs;
  logic out_hs;

  // State register
  always_ff @(posedge CLKI) begin
    if (!RSTI) begin
      state_q <= ST_LOAD;
      cnt_q   <= 3'd0;
      wait_q  <= 8'd0;
      pt_q    <= 64'd0;
      key_q   <= 64'd0;
      shift_q <= 64'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      pt_q    <= pt_d;
      key_q   <= key_d;
      shift_q <= shift_d;
    end
  end

  // Next state and datapath; everything holds while the chip is deselected
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wait_d  = wait_q;
    pt_d    = pt_q;
    key_d   = key_q;
    shift_d = shift_q;
    if (!bus.CHIP_BAR_I) begin
      case (state_q)
        ST_LOAD: begin
          if (in_hs) begin
            // {~cnt,3'b111} == 63 - 8*cnt: byte 0 lands in the top byte
            pt_d[{~cnt_q, 3'b111} -: 8]  = bus.PT_BYTE_I;
            key_d[{~cnt_q, 3'b111} -: 8] = bus.KEY_BYTE_I;
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              state_d = ST_START;
            end
          end
        end
        ST_START: begin
          wait_d  = C_LATENCY;
          state_d = ST_WAIT;
        end
        ST_WAIT: begin
          wait_d = wait_q - 8'd1;
          if (wait_q == 8'd1) begin
            shift_d = bus.DES_CIPHER_I;
            state_d = ST_UNLOAD;
          end
        end
        default: begin
          if (out_hs) begin
            shift_d = {shift_q[55:0], 8'h00};
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              state_d = ST_LOAD;
            end
          end
        end
      endcase
    end
  end

  // Outputs; handshake strobes are forced low during reset and while frozen
  always_comb begin
    run       = RSTI && !bus.CHIP_BAR_I;
    in_ready  = run && (state_q == ST_LOAD);
    out_valid = run && (state_q == ST_UNLOAD);
    in_hs     = in_ready && bus.IN_VALID;
    out_hs    = out_valid && bus.OUT_READY;

    bus.IN_READY      = in_ready;
    bus.OUT_VALID     = out_valid;
    bus.OUT_LAST      = out_valid && (cnt_q == 3'd7);
    bus.DES_START_O   = run && (state_q == ST_START);
    bus.BUSY          = RSTI && (state_q != ST_LOAD);
    bus.CIPHER_BYTE_O = shift_q[63:56];
    bus.DES_PT_O      = pt_q;
    bus.DES_KEY_O     = key_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_des_byte_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_des_byte_sequencer
// Brief    : Directed vector bench for des_byte_sequencer.
// Revision : 1.0
// ============================================================================
module tb_des_byte_sequencer;

  localparam int LAT = 16;

  typedef struct {
    logic [63:0] pt;
    logic [63:0] key;
    logic [63:0] cipher;
    int          gap;
    bit          bp;
    bit          frz;
    logic [63:0] exp_pt;
    logic [63:0] exp_key;
    logic [63:0] exp_out;
    int          exp_lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;

  des_byte_sequencer_if bus();

  des_byte_sequencer #(.DES_LATENCY(LAT)) dut (
    .CLKI (clk),
    .RSTI (rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic idle_inputs();
    bus.CHIP_BAR_I   = 1'b0;
    bus.IN_VALID     = 1'b0;
    bus.PT_BYTE_I    = 8'h00;
    bus.KEY_BYTE_I   = 8'h00;
    bus.OUT_READY    = 1'b0;
    bus.DES_CIPHER_I = 64'd0;
  endtask

  // Loads one block, models the core, drains the cipher and checks it all
  task automatic run_block(input vec_t v);
    int k_in = 0, k_out = 0, gap_ctr = 0, cyc = 0, starts = 0;
    int start_cyc = -1, valid_cyc = -1, ucyc = 0, frz_left = 0;
    bit wait_frz_done = 0, unl_frz_done = 0;
    bit ready_bad = 0, early_start = 0, frz_bad = 0;
    while (k_out < 8 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (v.frz && !wait_frz_done && starts > 0 && cyc == start_cyc + 3) begin
        frz_left = 5; wait_frz_done = 1;
      end
      if (v.frz && !unl_frz_done && k_out == 3) begin
        frz_left = 5; unl_frz_done = 1;
      end
      bus.CHIP_BAR_I = (frz_left > 0);
      if (frz_left > 0) frz_left--;
      if (k_in < 8) begin
        bus.IN_VALID   = (gap_ctr == 0);
        bus.PT_BYTE_I  = v.pt[63-8*k_in -: 8];
        bus.KEY_BYTE_I = v.key[63-8*k_in -: 8];
      end else begin
        bus.IN_VALID   = 1'b1;
        bus.PT_BYTE_I  = 8'hEE;
        bus.KEY_BYTE_I = 8'hEE;
      end
      bus.OUT_READY    = v.bp ? (ucyc % 3 == 0) : 1'b1;
      bus.DES_CIPHER_I = (starts > 0 && cyc == start_cyc + v.exp_lat - 1) ? v.cipher : ~v.cipher;
      #1;
      if (k_in == 8 && bus.IN_READY) ready_bad = 1;
      if (bus.CHIP_BAR_I && (bus.IN_READY || bus.OUT_VALID || bus.DES_START_O)) frz_bad = 1;
      if (bus.DES_START_O) begin
        starts++;
        if (starts == 1) begin
          start_cyc = cyc;
          chk("pt_at_start", bus.DES_PT_O, v.exp_pt);
          chk("key_at_start", bus.DES_KEY_O, v.exp_key);
        end
        if (k_in != 8) early_start = 1;
      end
      if (k_in < 8) begin
        if (bus.IN_VALID && bus.IN_READY) begin
          k_in++;
          gap_ctr = v.gap;
        end else if (gap_ctr > 0) begin
          gap_ctr--;
        end
      end
      if (bus.OUT_VALID) begin
        if (valid_cyc < 0) valid_cyc = cyc;
        chk($sformatf("byte%0d", k_out), bus.CIPHER_BYTE_O, v.exp_out[63-8*k_out -: 8]);
        chk($sformatf("last%0d", k_out), bus.OUT_LAST, (k_out == 7));
        ucyc++;
        if (bus.OUT_READY) k_out++;
      end
    end
    chk("bytes_done", k_out, 8);
    chk("start_count", starts, 1);
    chk("early_start", early_start, 0);
    chk("in_ready_low", ready_bad, 0);
    chk("freeze_outputs", frz_bad, 0);
    chk("latency", valid_cyc - start_cyc, v.exp_lat);
    chk("pt_hold", bus.DES_PT_O, v.exp_pt);
    chk("key_hold", bus.DES_KEY_O, v.exp_key);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("in_ready_back", bus.IN_READY, 1);
    chk("busy_clear", bus.BUSY, 0);
  endtask

  vec_t vecs[4];
  vec_t abort_vec;

  initial begin
    vecs[0] = '{64'h0123456789ABCDEF, 64'h133457799BBCDFF1, 64'h85E813540F0AB405, 0, 0, 0,
                64'h0123456789ABCDEF, 64'h133457799BBCDFF1, 64'h85E813540F0AB405, 17};
    vecs[1] = '{64'hFEDCBA9876543210, 64'h0E329232EA6D0D73, 64'h3A5C7E91B2D4F608, 0, 1, 0,
                64'hFEDCBA9876543210, 64'h0E329232EA6D0D73, 64'h3A5C7E91B2D4F608, 17};
    vecs[2] = '{64'h0123456789ABCDEF, 64'h133457799BBCDFF1, 64'h85E813540F0AB405, 2, 0, 0,
                64'h0123456789ABCDEF, 64'h133457799BBCDFF1, 64'h85E813540F0AB405, 17};
    vecs[3] = '{64'h1122334455667788, 64'hAABBCCDDEEFF0011, 64'hC0FFEE0123456789, 0, 1, 1,
                64'h1122334455667788, 64'hAABBCCDDEEFF0011, 64'hC0FFEE0123456789, 22};
    abort_vec = '{64'h0F1E2D3C4B5A6978, 64'h8796A5B4C3D2E1F0, 64'h5566778899AABBCC, 0, 0, 0,
                  64'h0F1E2D3C4B5A6978, 64'h8796A5B4C3D2E1F0, 64'h5566778899AABBCC, 17};

    // Reset held with IN_VALID high
    idle_inputs();
    bus.IN_VALID = 1'b1;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("rst_ctrl%0d", i),
          {bus.IN_READY, bus.OUT_VALID, bus.DES_START_O, bus.OUT_LAST, bus.BUSY}, 5'b0);
      chk($sformatf("rst_pt%0d", i), bus.DES_PT_O, 64'd0);
    end
    chk("rst_key", bus.DES_KEY_O, 64'd0);
    chk("rst_byte", bus.CIPHER_BYTE_O, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.IN_VALID = 1'b0;
    #1;
    chk("rst_release_ready", bus.IN_READY, 1);

    for (int i = 0; i < 4; i++) run_block(vecs[i]);

    // Abort after four accepted bytes
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.IN_VALID   = 1'b1;
      bus.PT_BYTE_I  = 8'hA0 + 8'(i);
      bus.KEY_BYTE_I = 8'hB0 + 8'(i);
      #1;
      chk($sformatf("abort_load%0d", i), bus.IN_READY, 1);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      rst_n = 1'b0;
      bus.IN_VALID = 1'b1;
      #1;
      chk($sformatf("abort_rst%0d", i), {bus.IN_READY, bus.DES_START_O, bus.BUSY}, 3'b0);
    end
    chk("abort_pt_cleared", bus.DES_PT_O, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.IN_VALID = 1'b0;
    #1;
    chk("abort_ready", bus.IN_READY, 1);
    run_block(abort_vec);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
